// File: rtl/wb_stage_if.sv
// Memory-stage to writeback-stage instruction handshake.
// The memory stage drives an instruction under valid; writeback answers with ready.
interface wb_stage_if;
  logic        valid;
  logic        ready;
  logic [4:0]  rd;
  logic        rd_we;
  logic        is_load;
  logic [2:0]  funct3;
  logic [1:0]  addr_lo;
  logic [31:0] alu;
  logic [31:0] mem_rdata;

  modport master (
    output valid, rd, rd_we, is_load, funct3, addr_lo, alu, mem_rdata,
    input  ready
  );

  modport slave (
    input  valid, rd, rd_we, is_load, funct3, addr_lo, alu, mem_rdata,
    output ready
  );
endinterface

// File: rtl/wb_stage.sv
// RV32 writeback stage: load alignment/extension, x0 suppression, load fault detection,
// a small skid FIFO absorbing register-file stalls, and a retired-instruction counter.
module wb_stage #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  wb_stage_if.slave        in_if,
  input  logic             wb_stall_i,
  output logic             wb_en_o,
  output logic [4:0]       wb_reg_o,
  output logic [31:0]      wb_val_o,
  output logic             load_fault_o,
  output logic [CNT_W-1:0] instret_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntBits = PtrW + 1;
  localparam logic [CntBits-1:0] DepthCnt = CntBits'(DEPTH);

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] value;
    logic        fault;
  } entry_t;

  entry_t              mem_q [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntBits-1:0]  count_q, count_d;
  logic                wb_en_q, wb_en_d;
  logic [4:0]          wb_reg_q, wb_reg_d;
  logic [31:0]         wb_val_q, wb_val_d;
  logic                fault_q, fault_d;
  logic [CNT_W-1:0]    instret_q, instret_d;

  logic [31:0] word;
  logic [31:0] load_val;
  logic        load_bad;
  entry_t      new_entry;
  entry_t      head;
  logic        fifo_empty;
  logic        push;
  logic        fifo_write;
  logic        fifo_read;
  logic        do_pop;

  // Load data alignment and legality, evaluated at accept time.
  always_comb begin
    word     = in_if.mem_rdata >> {in_if.addr_lo, 3'b000};
    load_val = '0;
    load_bad = 1'b0;
    case (in_if.funct3)
      3'b000: load_val = {{24{word[7]}}, word[7:0]};
      3'b100: load_val = {24'b0, word[7:0]};
      3'b001: begin
        load_val = {{16{word[15]}}, word[15:0]};
        load_bad = in_if.addr_lo[0];
      end
      3'b101: begin
        load_val = {16'b0, word[15:0]};
        load_bad = in_if.addr_lo[0];
      end
      3'b010: begin
        load_val = in_if.mem_rdata;
        load_bad = (in_if.addr_lo != 2'b00);
      end
      default: load_bad = 1'b1;
    endcase

    new_entry.fault = in_if.is_load && load_bad;
    new_entry.value = in_if.is_load ? load_val : in_if.alu;
    new_entry.rd    = in_if.rd;
    new_entry.we    = in_if.rd_we && (in_if.rd != 5'd0) && !new_entry.fault;
  end

  assign in_if.ready = (count_q < DepthCnt);
  assign fifo_empty  = (count_q == '0);
  assign push        = in_if.valid && in_if.ready;
  // An empty FIFO with no stall forwards the incoming entry without storing it.
  assign fifo_read   = !fifo_empty && !wb_stall_i;
  assign fifo_write  = push && !(fifo_empty && !wb_stall_i);
  assign do_pop      = !wb_stall_i && (!fifo_empty || push);
  assign head        = fifo_empty ? new_entry : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    wb_en_d   = 1'b0;
    fault_d   = 1'b0;
    wb_reg_d  = wb_reg_q;
    wb_val_d  = wb_val_q;
    instret_d = instret_q;

    if (fifo_write) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (fifo_read) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (fifo_write && !fifo_read) begin
      count_d = count_q + CntBits'(1);
    end else if (!fifo_write && fifo_read) begin
      count_d = count_q - CntBits'(1);
    end

    if (do_pop) begin
      wb_en_d  = head.we;
      wb_reg_d = head.rd;
      wb_val_d = head.value;
      fault_d  = head.fault;
      if (!head.fault) begin
        instret_d = instret_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wb_en_q   <= 1'b0;
      wb_reg_q  <= '0;
      wb_val_q  <= '0;
      fault_q   <= 1'b0;
      instret_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      wb_en_q   <= wb_en_d;
      wb_reg_q  <= wb_reg_d;
      wb_val_q  <= wb_val_d;
      fault_q   <= fault_d;
      instret_q <= instret_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (fifo_write) begin
      mem_q[wr_ptr_q] <= new_entry;
    end
  end

  assign wb_en_o      = wb_en_q;
  assign wb_reg_o     = wb_reg_q;
  assign wb_val_o     = wb_val_q;
  assign load_fault_o = fault_q;
  assign instret_o    = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage with hand-computed expectations.
module tb_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        wb_stall;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_val;
  logic        load_fault;
  logic [63:0] instret;

  int n_cmp = 0;
  int n_err = 0;

  wb_stage_if bus ();

  wb_stage #(
    .DEPTH (2),
    .CNT_W (64)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_if        (bus),
    .wb_stall_i   (wb_stall),
    .wb_en_o      (wb_en),
    .wb_reg_o     (wb_reg),
    .wb_val_o     (wb_val),
    .load_fault_o (load_fault),
    .instret_o    (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("mismatch in %s", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic we, input logic ld,
                       input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] alu,
                       input logic [31:0] rdata);
    bus.valid     = v;
    bus.rd        = rd;
    bus.rd_we     = we;
    bus.is_load   = ld;
    bus.funct3    = f3;
    bus.addr_lo   = lo;
    bus.alu       = alu;
    bus.mem_rdata = rdata;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
  endtask

  initial begin
    rst_n    = 1'b0;
    wb_stall = 1'b0;
    idle();
    step();
    step();
    chk("rst_wb_en", {63'b0, wb_en}, 64'd0);
    chk("rst_wb_reg", {59'b0, wb_reg}, 64'd0);
    chk("rst_wb_val", {32'b0, wb_val}, 64'd0);
    chk("rst_fault", {63'b0, load_fault}, 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_ready", {63'b0, bus.ready}, 64'd1);
    rst_n = 1'b1;

    // ALU op, bypass path
    drive(1'b1, 5'd5, 1'b1, 1'b0, 3'b000, 2'b00, 32'h1234_5678, 32'h0);
    step();
    idle();
    chk("alu_wb_en", {63'b0, wb_en}, 64'd1);
    chk("alu_wb_reg", {59'b0, wb_reg}, 64'd5);
    chk("alu_wb_val", {32'b0, wb_val}, 64'h1234_5678);
    chk("alu_instret", instret, 64'd1);
    step();
    chk("idle_wb_en", {63'b0, wb_en}, 64'd0);
    chk("idle_wb_val_hold", {32'b0, wb_val}, 64'h1234_5678);

    // Loads, back to back
    drive(1'b1, 5'd6, 1'b1, 1'b1, 3'b000, 2'd3, 32'h0, 32'h80FF_7F01);
    step();
    chk("lb_wb_en", {63'b0, wb_en}, 64'd1);
    chk("lb_wb_val", {32'b0, wb_val}, 64'hFFFF_FF80);
    chk("lb_wb_reg", {59'b0, wb_reg}, 64'd6);
    drive(1'b1, 5'd7, 1'b1, 1'b1, 3'b100, 2'd3, 32'h0, 32'h80FF_7F01);
    step();
    chk("lbu_wb_val", {32'b0, wb_val}, 64'h0000_0080);
    drive(1'b1, 5'd9, 1'b1, 1'b1, 3'b101, 2'd2, 32'h0, 32'h80FF_7F01);
    step();
    chk("lhu_wb_val", {32'b0, wb_val}, 64'h0000_80FF);
    chk("lhu_instret", instret, 64'd4);
    drive(1'b1, 5'd10, 1'b1, 1'b1, 3'b001, 2'd2, 32'h0, 32'h80FF_7F01);
    step();
    chk("lh_wb_val", {32'b0, wb_val}, 64'hFFFF_80FF);
    chk("lh_instret", instret, 64'd5);

    // Faulting loads
    drive(1'b1, 5'd8, 1'b1, 1'b1, 3'b010, 2'd2, 32'h0, 32'hDEAD_BEEF);
    step();
    idle();
    chk("lw_mis_wb_en", {63'b0, wb_en}, 64'd0);
    chk("lw_mis_fault", {63'b0, load_fault}, 64'd1);
    chk("lw_mis_instret", instret, 64'd5);
    step();
    chk("fault_pulse_end", {63'b0, load_fault}, 64'd0);
    drive(1'b1, 5'd8, 1'b1, 1'b1, 3'b001, 2'd1, 32'h0, 32'hDEAD_BEEF);
    step();
    chk("lh_mis_wb_en", {63'b0, wb_en}, 64'd0);
    chk("lh_mis_fault", {63'b0, load_fault}, 64'd1);
    chk("lh_mis_instret", instret, 64'd5);
    drive(1'b1, 5'd8, 1'b1, 1'b1, 3'b011, 2'd0, 32'h0, 32'hDEAD_BEEF);
    step();
    chk("illegal_f3_fault", {63'b0, load_fault}, 64'd1);
    chk("illegal_f3_wb_en", {63'b0, wb_en}, 64'd0);

    // Aligned LW and x0 write
    drive(1'b1, 5'd11, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0, 32'hCAFE_F00D);
    step();
    chk("lw_wb_val", {32'b0, wb_val}, 64'hCAFE_F00D);
    chk("lw_fault", {63'b0, load_fault}, 64'd0);
    drive(1'b1, 5'd0, 1'b1, 1'b0, 3'b000, 2'd0, 32'h5555_AAAA, 32'h0);
    step();
    idle();
    chk("x0_wb_en", {63'b0, wb_en}, 64'd0);
    chk("x0_instret", instret, 64'd7);

    // Stall: fill FIFO, third is refused
    wb_stall = 1'b1;
    drive(1'b1, 5'd12, 1'b1, 1'b0, 3'b000, 2'd0, 32'hA0, 32'h0);
    chk("stall_ready0", {63'b0, bus.ready}, 64'd1);
    step();
    drive(1'b1, 5'd13, 1'b1, 1'b0, 3'b000, 2'd0, 32'hB0, 32'h0);
    chk("stall_ready1", {63'b0, bus.ready}, 64'd1);
    chk("stall_wb_en", {63'b0, wb_en}, 64'd0);
    step();
    drive(1'b1, 5'd14, 1'b1, 1'b0, 3'b000, 2'd0, 32'hC0, 32'h0);
    chk("full_ready", {63'b0, bus.ready}, 64'd0);
    step();
    chk("full_ready_hold", {63'b0, bus.ready}, 64'd0);
    chk("full_wb_en", {63'b0, wb_en}, 64'd0);
    wb_stall = 1'b0;
    step();
    chk("drain0_wb_en", {63'b0, wb_en}, 64'd1);
    chk("drain0_wb_reg", {59'b0, wb_reg}, 64'd12);
    chk("drain0_wb_val", {32'b0, wb_val}, 64'hA0);
    chk("drain0_ready", {63'b0, bus.ready}, 64'd1);
    step();
    idle();
    chk("drain1_wb_reg", {59'b0, wb_reg}, 64'd13);
    chk("drain1_wb_val", {32'b0, wb_val}, 64'hB0);
    step();
    chk("drain2_wb_en", {63'b0, wb_en}, 64'd1);
    chk("drain2_wb_reg", {59'b0, wb_reg}, 64'd14);
    chk("drain2_wb_val", {32'b0, wb_val}, 64'hC0);
    chk("drain_instret", instret, 64'd10);
    step();
    chk("drained_wb_en", {63'b0, wb_en}, 64'd0);

    // Reset with FIFO full
    wb_stall = 1'b1;
    drive(1'b1, 5'd15, 1'b1, 1'b0, 3'b000, 2'd0, 32'hD0, 32'h0);
    step();
    drive(1'b1, 5'd16, 1'b1, 1'b0, 3'b000, 2'd0, 32'hE0, 32'h0);
    step();
    idle();
    chk("prerst_ready", {63'b0, bus.ready}, 64'd0);
    rst_n = 1'b0;
    step();
    chk("midrst_wb_en", {63'b0, wb_en}, 64'd0);
    chk("midrst_instret", instret, 64'd0);
    chk("midrst_ready", {63'b0, bus.ready}, 64'd1);
    rst_n    = 1'b1;
    wb_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("postrst_no_write", {63'b0, wb_en}, 64'd0);
    end
    chk("postrst_instret", instret, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
